// File: rtl/centroid_track_ctrl.sv
// Frame-level tracking controller between the centroid unit and the visualiser:
// counts mask pixels, samples the centroid once per frame in vblank, smooths and gates the overlay.
module centroid_track_ctrl #(
  parameter int unsigned SAMPLE_DELAY = 16,
  parameter int unsigned MIN_AREA     = 32,
  parameter int unsigned MAX_MISS     = 4,
  parameter int unsigned ALPHA_SHIFT  = 1,
  parameter int unsigned AREA_W       = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de,
  input  logic              vsync,
  input  logic              mask,
  input  logic [10:0]       x_in,
  input  logic [10:0]       y_in,
  output logic [10:0]       x_out,
  output logic [10:0]       y_out,
  output logic              vis_en,
  output logic              track_valid,
  output logic [AREA_W-1:0] area,
  output logic              frame_tick
);

  localparam int unsigned COORD_W = 11;
  localparam int unsigned DLY_W   = (SAMPLE_DELAY < 2) ? 1 : $clog2(SAMPLE_DELAY + 1);
  localparam int unsigned MISS_W  = (MAX_MISS < 2) ? 1 : $clog2(MAX_MISS + 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACQUIRE     = 2'd1,
    WAIT_SAMPLE = 2'd2,
    DECIDE      = 2'd3
  } state_t;

  state_t                   state;
  logic                     vsync_d;
  logic                     vs_rise;
  logic                     vs_fall;
  logic                     pix_hit;
  logic [AREA_W-1:0]        pix_cnt;
  logic [AREA_W-1:0]        pix_cnt_inc;
  logic [AREA_W-1:0]        area_snap;
  logic [DLY_W-1:0]         dly_cnt;
  logic [MISS_W-1:0]        miss_cnt;
  logic [MISS_W-1:0]        miss_inc;
  logic                     area_ok;
  logic signed [COORD_W:0]  dx;
  logic signed [COORD_W:0]  dy;
  logic [COORD_W-1:0]       x_smooth;
  logic [COORD_W-1:0]       y_smooth;

  // Frame edges, saturating pixel count, miss counter and the smoothing step.
  always_comb begin
    vs_rise     = vsync & ~vsync_d;
    vs_fall     = ~vsync & vsync_d;
    pix_hit     = de & mask;
    pix_cnt_inc = (pix_hit && !(&pix_cnt)) ? pix_cnt + AREA_W'(1) : pix_cnt;
    miss_inc    = (32'(miss_cnt) >= MAX_MISS) ? MISS_W'(MAX_MISS) : miss_cnt + MISS_W'(1);
    area_ok     = (area_snap >= AREA_W'(MIN_AREA));
    dx          = $signed({1'b0, x_in}) - $signed({1'b0, x_out});
    dy          = $signed({1'b0, y_in}) - $signed({1'b0, y_out});
    // Step lies between the two operands, so the 11-bit sum cannot wrap.
    x_smooth    = x_out + COORD_W'(dx >>> ALPHA_SHIFT);
    y_smooth    = y_out + COORD_W'(dy >>> ALPHA_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vsync_d     <= 1'b0;
      pix_cnt     <= '0;
      area_snap   <= '0;
      dly_cnt     <= '0;
      miss_cnt    <= '0;
      x_out       <= '0;
      y_out       <= '0;
      vis_en      <= 1'b0;
      track_valid <= 1'b0;
      area        <= '0;
      frame_tick  <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= 1'b0;

      // The counter snapshots and restarts on every frame edge, whatever the FSM state.
      if (vs_rise) begin
        area_snap <= pix_cnt_inc;
        pix_cnt   <= AREA_W'(pix_hit);
      end else begin
        pix_cnt   <= pix_cnt_inc;
      end

      unique case (state)
        IDLE: begin
          if (vs_rise) state <= ACQUIRE;
        end
        ACQUIRE: begin
          if (vs_rise) begin
            state   <= WAIT_SAMPLE;
            dly_cnt <= DLY_W'(SAMPLE_DELAY);
          end
        end
        WAIT_SAMPLE: begin
          if (dly_cnt != '0) dly_cnt <= dly_cnt - DLY_W'(1);
          if ((dly_cnt <= DLY_W'(1)) || vs_fall) state <= DECIDE;
        end
        DECIDE: begin
          state      <= ACQUIRE;
          area       <= area_snap;
          frame_tick <= 1'b1;
          if (area_ok) begin
            miss_cnt    <= '0;
            track_valid <= 1'b1;
            vis_en      <= 1'b1;
            if (!track_valid) begin
              x_out <= x_in;
              y_out <= y_in;
            end else begin
              x_out <= x_smooth;
              y_out <= y_smooth;
            end
          end else begin
            miss_cnt <= miss_inc;
            if (miss_inc == MISS_W'(MAX_MISS)) begin
              track_valid <= 1'b0;
              vis_en      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_track_ctrl.sv
// Bench for centroid_track_ctrl: two parameterisations driven with the same video stream,
// each compared against a frame-level model of the tracking rules.
module tb_centroid_track_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        de;
  logic        vsync;
  logic        mask;
  logic [10:0] x_in;
  logic [10:0] y_in;

  logic [10:0] x_out1, y_out1, x_out2, y_out2;
  logic        vis1, vis2, tv1, tv2, tick1, tick2;
  logic [21:0] area1;
  logic [5:0]  area2;

  centroid_track_ctrl u_dut1 (
    .clk(clk), .rst(rst), .de(de), .vsync(vsync), .mask(mask),
    .x_in(x_in), .y_in(y_in), .x_out(x_out1), .y_out(y_out1),
    .vis_en(vis1), .track_valid(tv1), .area(area1), .frame_tick(tick1)
  );

  centroid_track_ctrl #(
    .SAMPLE_DELAY(3), .MIN_AREA(32), .MAX_MISS(0), .ALPHA_SHIFT(0), .AREA_W(6)
  ) u_dut2 (
    .clk(clk), .rst(rst), .de(de), .vsync(vsync), .mask(mask),
    .x_in(x_in), .y_in(y_in), .x_out(x_out2), .y_out(y_out2),
    .vis_en(vis2), .track_valid(tv2), .area(area2), .frame_tick(tick2)
  );

  always #5 clk = ~clk;

  // Model parameters, one entry per instance.
  int sd[2]    = '{16, 3};
  int min_a[2] = '{32, 32};
  int mmiss[2] = '{4, 0};
  int ash[2]   = '{1, 0};
  int amax[2]  = '{(1 << 22) - 1, 63};

  int m_x[2], m_y[2], m_tv[2], m_miss[2], m_area[2];
  bit m_started[2];
  int pixcnt;
  bit moved;
  int lat_obs[2];
  logic [57:0] obs[2];
  logic [57:0] exp_v[2];

  int total = 0;
  int bad   = 0;

  function automatic logic [57:0] pk(input int ticks, input int lat, input int ar,
                                     input int x, input int y, input int vis, input int tv);
    return {4'(ticks), 8'(lat), 22'(ar), 11'(x), 11'(y), 1'(vis), 1'(tv)};
  endfunction

  function automatic int floor_div(input int a, input int p);
    int q;
    q = a / p;
    if ((a % p != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_tv[i] = 0; m_miss[i] = 0; m_area[i] = 0;
      m_started[i] = 1'b0;
    end
    pixcnt = 0;
  endtask

  task automatic do_reset();
    de = 1'b0; mask = 1'b0; vsync = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    model_reset();
  endtask

  // One active frame: w x h pixels with two blank cycles per line; mask inside a box at a given density.
  task automatic drive_active(input int w, input int h, input int c0, input int c1,
                              input int r0, input int r1, input int dens);
    logic [43:0] prev;
    prev = {x_out1, y_out1, x_out2, y_out2};
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        de   = 1'b1;
        mask = (c >= c0) && (c <= c1) && (r >= r0) && (r <= r1) &&
               (int'($urandom_range(99)) < dens);
        if (mask) pixcnt++;
        cyc();
        if ({x_out1, y_out1, x_out2, y_out2} !== prev) moved = 1'b1;
      end
      de = 1'b0; mask = 1'b0;
      cyc(); cyc();
    end
  endtask

  // Vertical blanking with vsync high for L cycles; model decides, DUT outputs are gathered.
  task automatic run_vsync(input int L);
    int n[2];
    int l[2];
    int cnt, tk, lt;
    for (int i = 0; i < 2; i++) begin
      cnt = (pixcnt > amax[i]) ? amax[i] : pixcnt;
      tk = 0; lt = 255;
      if (!m_started[i]) begin
        m_started[i] = 1'b1;
      end else begin
        tk = 1;
        lt = ((L < sd[i]) ? L : sd[i]) + 2;
        m_area[i] = cnt;
        if (cnt >= min_a[i]) begin
          if (m_tv[i] != 0) begin
            m_x[i] = m_x[i] + floor_div(int'(x_in) - m_x[i], 1 << ash[i]);
            m_y[i] = m_y[i] + floor_div(int'(y_in) - m_y[i], 1 << ash[i]);
          end else begin
            m_x[i] = int'(x_in);
            m_y[i] = int'(y_in);
          end
          m_tv[i] = 1; m_miss[i] = 0;
        end else begin
          m_miss[i] = (m_miss[i] + 1 > mmiss[i]) ? mmiss[i] : m_miss[i] + 1;
          if (m_miss[i] == mmiss[i]) m_tv[i] = 0;
        end
      end
      exp_v[i] = pk(tk, lt, m_area[i], m_x[i], m_y[i], m_tv[i], m_tv[i]);
      n[i] = 0; l[i] = 255;
    end
    pixcnt = 0;
    vsync = 1'b1;
    for (int k = 0; k < L + 30; k++) begin
      if (k == L) vsync = 1'b0;
      @(negedge clk);
      if (tick1) begin n[0]++; if (l[0] == 255) l[0] = k; end
      if (tick2) begin n[1]++; if (l[1] == 255) l[1] = k; end
      @(posedge clk);
      #1;
    end
    lat_obs[0] = l[0]; lat_obs[1] = l[1];
    obs[0] = pk(n[0], l[0], int'(area1), int'(x_out1), int'(y_out1), int'(vis1), int'(tv1));
    obs[1] = pk(n[1], l[1], int'(area2), int'(x_out2), int'(y_out2), int'(vis2), int'(tv2));
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({x_out1, y_out1, vis1, tv1, area1, tick1} !== '0) begin
      bad++;
      $display("FAIL reset_dut1: got %h want 0", {x_out1, y_out1, vis1, tv1, area1, tick1});
    end
    total++;
    if ({x_out2, y_out2, vis2, tv2, area2, tick2} !== '0) begin
      bad++;
      $display("FAIL reset_dut2: got %h want 0", {x_out2, y_out2, vis2, tv2, area2, tick2});
    end
    cyc();
  endtask

  task automatic test_first_lock();
    x_in = 11'd20; y_in = 11'd30;
    for (int f = 0; f < 2; f++) begin
      drive_active(64, 64, 15, 24, 25, 34, 100);
      run_vsync(20);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL first_lock f%0d dut%0d: got %h want %h", f, i + 1, obs[i], exp_v[i]);
        end
      end
    end
    total++;
    if ({x_out1, y_out1, area1, vis1, tv1} !== {11'd20, 11'd30, 22'd100, 1'b1, 1'b1} ||
        lat_obs[0] != 18) begin
      bad++;
      $display("FAIL first_lock_abs: got x=%0d y=%0d area=%0d vis=%b tv=%b lat=%0d want 20 30 100 1 1 18",
               x_out1, y_out1, area1, vis1, tv1, lat_obs[0]);
    end
  endtask

  task automatic test_smoothing();
    x_in = 11'd40; y_in = 11'd10;
    for (int f = 0; f < 2; f++) begin
      drive_active(8, 5, 0, 7, 0, 4, 100);
      run_vsync(20);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL smoothing f%0d dut%0d: got %h want %h", f, i + 1, obs[i], exp_v[i]);
        end
      end
    end
    total++;
    if (x_out1 !== 11'd35 || y_out1 !== 11'd15 || x_out2 !== 11'd40 || y_out2 !== 11'd10) begin
      bad++;
      $display("FAIL smoothing_abs: got %0d,%0d / %0d,%0d want 35,15 / 40,10",
               x_out1, y_out1, x_out2, y_out2);
    end
  endtask

  task automatic test_loss();
    for (int f = 0; f < 4; f++) begin
      x_in = 11'($urandom_range(2047)); y_in = 11'($urandom_range(2047));
      drive_active(5, 4, 0, 4, 0, 3, 100);
      run_vsync(20);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL loss f%0d dut%0d: got %h want %h", f, i + 1, obs[i], exp_v[i]);
        end
      end
      total++;
      if (tv1 !== (f < 3) || vis1 !== (f < 3) || x_out1 !== 11'd35) begin
        bad++;
        $display("FAIL loss_abs f%0d: got tv=%b vis=%b x=%0d want tv=%b x=35", f, tv1, vis1, x_out1, f < 3);
      end
    end
    x_in = 11'd50; y_in = 11'd50;
    drive_active(8, 5, 0, 7, 0, 4, 100);
    run_vsync(20);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== exp_v[i]) begin
        bad++;
        $display("FAIL reacquire dut%0d: got %h want %h", i + 1, obs[i], exp_v[i]);
      end
    end
    total++;
    if (x_out1 !== 11'd50 || y_out1 !== 11'd50 || tv1 !== 1'b1) begin
      bad++;
      $display("FAIL reacquire_abs: got %0d,%0d tv=%b want 50,50 tv=1", x_out1, y_out1, tv1);
    end
  endtask

  task automatic test_short_vsync();
    x_in = 11'd60; y_in = 11'd70;
    drive_active(8, 5, 0, 7, 0, 4, 100);
    run_vsync(5);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== exp_v[i]) begin
        bad++;
        $display("FAIL short_vsync dut%0d: got %h want %h", i + 1, obs[i], exp_v[i]);
      end
    end
    total++;
    if (lat_obs[0] != 7) begin
      bad++;
      $display("FAIL short_vsync_lat: got %0d want 7", lat_obs[0]);
    end
  endtask

  task automatic test_saturation();
    drive_active(64, 64, 0, 63, 0, 63, 100);
    run_vsync(20);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== exp_v[i]) begin
        bad++;
        $display("FAIL saturation dut%0d: got %h want %h", i + 1, obs[i], exp_v[i]);
      end
    end
    total++;
    if (area2 !== 6'd63 || tv2 !== 1'b1 || area1 !== 22'd4096) begin
      bad++;
      $display("FAIL saturation_abs: got area2=%0d tv2=%b area1=%0d want 63 1 4096", area2, tv2, area1);
    end
  endtask

  task automatic test_random();
    int w, h, L;
    moved = 1'b0;
    for (int f = 0; f < 14; f++) begin
      w = int'($urandom_range(12, 6));
      h = int'($urandom_range(10, 4));
      L = int'($urandom_range(24, 2));
      x_in = 11'($urandom_range(2047)); y_in = 11'($urandom_range(2047));
      drive_active(w, h, 0, w - 1, 0, h - 1, int'($urandom_range(100)));
      run_vsync(L);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL random f%0d dut%0d L=%0d: got %h want %h", f, i + 1, L, obs[i], exp_v[i]);
        end
      end
    end
    total++;
    if (moved !== 1'b0) begin
      bad++;
      $display("FAIL coords_stable_in_active: got moved=%b want 0", moved);
    end
  endtask

  task automatic test_reset_mid();
    x_in = 11'd300; y_in = 11'd400;
    drive_active(8, 5, 0, 7, 0, 4, 100);
    run_vsync(20);
    total++;
    if (obs[0] !== exp_v[0] || tv1 !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_track: got %h want %h", obs[0], exp_v[0]);
    end
    drive_active(8, 3, 0, 7, 0, 2, 100);
    rst = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if ({x_out1, y_out1, vis1, tv1, area1, x_out2, y_out2, vis2, tv2, area2} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %h want 0",
               {x_out1, y_out1, vis1, tv1, area1, x_out2, y_out2, vis2, tv2, area2});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int f = 0; f < 2; f++) begin
      drive_active(8, 5, 0, 7, 0, 4, 100);
      run_vsync(20);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_v[i]) begin
          bad++;
          $display("FAIL after_reset f%0d dut%0d: got %h want %h", f, i + 1, obs[i], exp_v[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; de = 1'b0; vsync = 1'b0; mask = 1'b0;
    x_in = '0; y_in = '0;
    moved = 1'b0;
    model_reset();
    test_reset();
    test_first_lock();
    test_smoothing();
    test_loss();
    test_short_vsync();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/centroid_track_ctrl.md
Name: centroid_track_ctrl

Overview:
- Frame-level controller between the centroid unit and the centroid visualiser in the HDMI pipeline.
- Counts mask pixels per frame and samples the centroid result once per frame during vertical blanking.
- Decides per frame whether the target is present, smooths the coordinates and holds them stable for the whole next frame.
- Tracks lost frames and gates the overlay through vis_en.

Parameters:
- SAMPLE_DELAY, 16: clk cycles after vsync rising edge before x_in/y_in are sampled (centroid divider latency).
- MIN_AREA, 32: minimum mask pixel count for a frame to be a valid detection.
- MAX_MISS, 4: consecutive invalid frames tolerated before the track is dropped.
- ALPHA_SHIFT, 1: smoothing shift; 0 disables smoothing.
- AREA_W, 22: mask pixel counter width.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- de  in  1  data enable
- vsync  in  1  vertical sync, active-high
- mask  in  1  binary object mask, qualified by de
- x_in  in  11  centroid x from centroid unit
- y_in  in  11  centroid y from centroid unit
- x_out  out  11  stabilised x to visualiser
- y_out  out  11  stabilised y to visualiser
- vis_en  out  1  overlay enable
- track_valid  out  1  target currently tracked
- area  out  AREA_W  mask pixel count of the last complete frame
- frame_tick  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset values: x_out=0, y_out=0, vis_en=0, track_valid=0, area=0, frame_tick=0, miss_cnt=0, FSM=IDLE, pixel counter=0, vsync_d=0.
- Frame edge: vs_rise = vsync & ~vsync_d, using a registered vsync.
- Pixel counter:
  - Increments on de&mask.
  - Saturates at all-ones.
  - On vs_rise, its value (including the current pixel if de&mask) is snapshotted into area_snap and the counter restarts at 0, or at 1 if de&mask in the same cycle.
- FSM states:
  - IDLE: wait for vs_rise, then go to ACQUIRE. That frame is partial, so its snapshot is discarded.
  - ACQUIRE: count the full frame; on vs_rise go to WAIT_SAMPLE and load the delay counter with SAMPLE_DELAY.
  - WAIT_SAMPLE: decrement the delay counter. Go to DECIDE when the counter reaches 0 or vsync falls, whichever is first.
  - DECIDE: single cycle, then back to ACQUIRE.
- DECIDE actions:
  - area <= area_snap; frame_tick=1.
  - If area_snap >= MIN_AREA (valid frame):
    - miss_cnt <= 0; track_valid <= 1; vis_en <= 1.
    - If track_valid was 0, x_out/y_out load x_in/y_in directly.
    - Otherwise x_out <= x_out + ((x_in - x_out) >>> ALPHA_SHIFT), same for y. Use 12-bit signed difference and arithmetic shift; the result is always within [min,max] of the operands, so no overflow.
  - Otherwise (invalid frame):
    - x_out/y_out hold their values.
    - miss_cnt increments, saturating at MAX_MISS.
    - When the incremented value equals MAX_MISS: track_valid <= 0, vis_en <= 0.
- x_out/y_out change only in DECIDE, i.e. during vertical blanking, never during active video.
- First valid decision occurs in the second vsync after reset release.
- Latency from the sampling vs_rise to the output update is SAMPLE_DELAY+2 cycles when vsync stays high long enough.
- A vs_rise during WAIT_SAMPLE or DECIDE is impossible by video timing. If one occurs anyway, it still snapshots and clears the counter, and the FSM ignores it.
- rst mid-frame returns everything to reset values. The FSM waits through one partial frame (IDLE) again.
- MAX_MISS=0 means any invalid frame drops the track immediately.

Test Plan:
- Reset then two 64x64 frames, each with a 10x10 mask block centred at (20,30) and x_in=20, y_in=30 → no frame_tick after the first vsync. At the second vsync, frame_tick fires SAMPLE_DELAY+2 cycles after vs_rise with area=100, x_out=20, y_out=30, vis_en=1, track_valid=1.
- Smoothing, ALPHA_SHIFT=1: tracked at (20,30), next valid frame x_in=40, y_in=10 → x_out=30, y_out=20. Following frame with the same inputs → x_out=35, y_out=15.
- Loss: tracked, then frames with 20 mask pixels → frames 1-3 hold coords with vis_en=1 and track_valid=1. After frame 4, track_valid=0 and vis_en=0. The next valid frame at (50,50) loads x_out=50 directly, no smoothing.
- Short vsync: SAMPLE_DELAY=16, vsync high for 5 cycles → sampling occurs at vsync fall; frame_tick one cycle later.
- Saturation, AREA_W=6: full 64x64 mask frame → area=63, valid frame.
- rst asserted mid-frame while tracking → outputs 0 next cycle. The first frame_tick after release comes only after two further vs_rise.
